// File: rtl/s100_ctl_seq_pkg.sv
// rtl/s100_ctl_seq_pkg.sv - shared definitions for the S-100 control-bus sequencer
//
// Purpose: state encoding, ctl_out bit positions and the Z80 cycle-start
// decode shared by the sequencer and its bench-facing documentation.
// Ports: none (package).

package s100_ctl_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    STVAL  = 3'd2,
    STROBE = 3'd3,
    DONE   = 3'd4,
    HOLD   = 3'd5
  } state_t;

  localparam int CTL_PSYNC  = 4;
  localparam int CTL_PSTVAL = 3;
  localparam int CTL_PDBIN  = 2;
  localparam int CTL_PWR    = 1;
  localparam int CTL_SINTA  = 0;

  // A bus cycle is a memory read/write, an I/O read/write, or an interrupt
  // acknowledge (IORQ together with M1).
  function automatic logic cycle_start(input logic mreq_n, input logic iorq_n,
                                       input logic rd_n, input logic wr_n,
                                       input logic m1_n);
    return (!mreq_n && (!rd_n || !wr_n)) ||
           (!iorq_n && (!rd_n || !wr_n || !m1_n));
  endfunction

endpackage

// File: rtl/s100_ctl_seq_strobe_cnt.sv
// rtl/s100_ctl_seq_strobe_cnt.sv - loadable saturating down-counter with zero flag
//
// Purpose: times the minimum strobe width of a bus cycle.
// Ports:
//   clock, reset     clock and asynchronous active-high reset
//   load, load_val   load load_val on the next edge (takes priority over dec)
//   dec              decrement by one, holding at zero
//   zero             count is zero

module s100_ctl_seq_strobe_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/s100_ctl_seq.sv
// rtl/s100_ctl_seq.sv - Z80 strobe to S-100 control vector sequencer with hold arbitration
//
// Purpose: turns Z80 MREQ/IORQ/RD/WR/M1 into the timed S-100 control vector
// {psync, pstval, pdbin, pwr, sinta}, stalls the Z80 with WAIT until the
// strobe is long enough and the bus is ready, and grants DMA hold between
// cycles.
// Ports:
//   clock, reset                      clock, asynchronous active-high reset
//   z80_mreq_n .. z80_m1_n            Z80 strobes, active-low
//   s100_xrdy, s100_prdy              bus ready, active-high
//   hold_req                          DMA hold request
//   ctl_out[4:0]                      control vector to the mux
//   ctl_sel                           mux select, 1 = bus released
//   phlda                             hold acknowledge
//   z80_wait_n                        Z80 WAIT, active-low
//   busy                              sequencer not idle
// All outputs are registered.

module s100_ctl_seq
  import s100_ctl_seq_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int IO_EXTRA    = 1,
  parameter int CNT_W       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       z80_mreq_n,
  input  logic       z80_iorq_n,
  input  logic       z80_rd_n,
  input  logic       z80_wr_n,
  input  logic       z80_m1_n,
  input  logic       s100_xrdy,
  input  logic       s100_prdy,
  input  logic       hold_req,
  output logic [4:0] ctl_out,
  output logic       ctl_sel,
  output logic       phlda,
  output logic       z80_wait_n,
  output logic       busy
);

  localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] IO_LOAD  = CNT_W'(WAIT_CYCLES + IO_EXTRA);

  state_t state, state_nxt;

  logic is_rd, is_wr, is_io, is_inta;
  logic is_rd_nxt, is_wr_nxt, is_io_nxt, is_inta_nxt;

  logic [4:0] ctl_nxt;
  logic       sel_nxt, hlda_nxt, wait_n_nxt, busy_nxt;

  logic cyc_start;
  logic ready;
  logic cnt_zero;

  assign cyc_start = cycle_start(z80_mreq_n, z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n);
  assign ready     = s100_xrdy & s100_prdy;

  s100_ctl_seq_strobe_cnt #(
    .CNT_W(CNT_W)
  ) u_strobe_cnt (
    .clock   (clock),
    .reset   (reset),
    .load    (state == STVAL),
    .load_val(is_io ? IO_LOAD : MEM_LOAD),
    .dec     (state == STROBE),
    .zero    (cnt_zero)
  );

  // Next state and cycle attributes.
  always_comb begin
    state_nxt   = state;
    is_rd_nxt   = is_rd;
    is_wr_nxt   = is_wr;
    is_io_nxt   = is_io;
    is_inta_nxt = is_inta;

    unique case (state)
      IDLE: begin
        if (cyc_start) begin
          // A cycle start beats a simultaneous hold request; the hold is
          // picked up the next time the sequencer is idle.
          state_nxt   = SYNC;
          is_inta_nxt = !z80_iorq_n && !z80_m1_n;
          is_rd_nxt   = !z80_rd_n || is_inta_nxt;
          is_wr_nxt   = !z80_wr_n && !is_rd_nxt;
          is_io_nxt   = !z80_iorq_n;
        end else if (hold_req) begin
          state_nxt = HOLD;
        end
      end
      SYNC:   state_nxt = STVAL;
      STVAL:  state_nxt = STROBE;
      STROBE: if (cnt_zero && ready) state_nxt = DONE;
      // Wait for the Z80 to finish the cycle so it is not recognised twice.
      DONE:   if (z80_mreq_n && z80_iorq_n) state_nxt = IDLE;
      HOLD:   if (!hold_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output values decoded from the state being entered, so the registered
  // outputs change on the same edge as the state.
  always_comb begin
    ctl_nxt    = '0;
    sel_nxt    = 1'b0;
    hlda_nxt   = 1'b0;
    wait_n_nxt = 1'b1;
    busy_nxt   = (state_nxt != IDLE);

    unique case (state_nxt)
      SYNC: begin
        ctl_nxt[CTL_PSYNC] = 1'b1;
        ctl_nxt[CTL_SINTA] = is_inta_nxt;
        wait_n_nxt         = 1'b0;
      end
      STVAL: begin
        ctl_nxt[CTL_PSTVAL] = 1'b1;
        ctl_nxt[CTL_SINTA]  = is_inta_nxt;
        wait_n_nxt          = 1'b0;
      end
      STROBE: begin
        ctl_nxt[CTL_PDBIN] = is_rd_nxt;
        ctl_nxt[CTL_PWR]   = is_wr_nxt;
        ctl_nxt[CTL_SINTA] = is_inta_nxt;
        wait_n_nxt         = 1'b0;
      end
      HOLD: begin
        // Bus is released one edge after HOLD is entered; a Z80 cycle that
        // starts meanwhile is only stalled, and is sequenced after release.
        sel_nxt    = (state == HOLD);
        hlda_nxt   = (state == HOLD);
        wait_n_nxt = !cyc_start;
      end
      default: begin
        ctl_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      is_rd      <= 1'b0;
      is_wr      <= 1'b0;
      is_io      <= 1'b0;
      is_inta    <= 1'b0;
      ctl_out    <= '0;
      ctl_sel    <= 1'b0;
      phlda      <= 1'b0;
      z80_wait_n <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      is_rd      <= is_rd_nxt;
      is_wr      <= is_wr_nxt;
      is_io      <= is_io_nxt;
      is_inta    <= is_inta_nxt;
      ctl_out    <= ctl_nxt;
      ctl_sel    <= sel_nxt;
      phlda      <= hlda_nxt;
      z80_wait_n <= wait_n_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_s100_ctl_seq.sv
// tb/tb_s100_ctl_seq.sv - self-checking bench for the S-100 control-bus sequencer

module tb_s100_ctl_seq;

  localparam int WAIT_CYCLES = 1;
  localparam int IO_EXTRA    = 1;
  localparam int CNT_W       = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       z80_mreq_n, z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n;
  logic       s100_xrdy, s100_prdy, hold_req;
  logic [4:0] ctl_out;
  logic       ctl_sel, phlda, z80_wait_n, busy;
  logic [8:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  s100_ctl_seq #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .IO_EXTRA   (IO_EXTRA),
    .CNT_W      (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .z80_mreq_n(z80_mreq_n),
    .z80_iorq_n(z80_iorq_n),
    .z80_rd_n  (z80_rd_n),
    .z80_wr_n  (z80_wr_n),
    .z80_m1_n  (z80_m1_n),
    .s100_xrdy (s100_xrdy),
    .s100_prdy (s100_prdy),
    .hold_req  (hold_req),
    .ctl_out   (ctl_out),
    .ctl_sel   (ctl_sel),
    .phlda     (phlda),
    .z80_wait_n(z80_wait_n),
    .busy      (busy)
  );

  assign obs = {ctl_out, ctl_sel, phlda, z80_wait_n, busy};

  // Expected output bundle {ctl_out, ctl_sel, phlda, z80_wait_n, busy}.
  function automatic logic [8:0] ev(input logic [4:0] c, input logic sel,
                                    input logic hlda, input logic wn, input logic b);
    return {c, sel, hlda, wn, b};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (ctl,sel,hlda,wait_n,busy)", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // kind: 0 mem rd, 1 mem wr, 2 io rd, 3 io wr, 4 inta, 5 mem rd+wr, other = idle
  task automatic set_z80(input int kind);
    z80_mreq_n = 1'b1; z80_iorq_n = 1'b1; z80_rd_n = 1'b1; z80_wr_n = 1'b1; z80_m1_n = 1'b1;
    case (kind)
      0: begin z80_mreq_n = 1'b0; z80_rd_n = 1'b0; end
      1: begin z80_mreq_n = 1'b0; z80_wr_n = 1'b0; end
      2: begin z80_iorq_n = 1'b0; z80_rd_n = 1'b0; end
      3: begin z80_iorq_n = 1'b0; z80_wr_n = 1'b0; end
      4: begin z80_iorq_n = 1'b0; z80_m1_n = 1'b0; end
      5: begin z80_mreq_n = 1'b0; z80_rd_n = 1'b0; z80_wr_n = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic set_ready(input logic ok);
    int pick;
    if (ok) begin
      s100_xrdy = 1'b1; s100_prdy = 1'b1;
    end else begin
      pick = $urandom_range(0, 2);
      s100_xrdy = (pick == 1);
      s100_prdy = (pick == 0);
    end
  endtask

  // One complete bus cycle from IDLE, checked clock by clock against a trace
  // built from the cycle type: SYNC, STVAL, a strobe of max(load, r)+1 clocks
  // (ready held low for the first r strobe clocks), then DONE until released.
  task automatic run_txn(input int kind, input int r, input logic hold);
    logic       io, rdv, wrv, sinta;
    logic [4:0] sv, expc;
    int         load, width, extra;
    string      tag;
    io    = (kind == 2) || (kind == 3) || (kind == 4);
    sinta = (kind == 4);
    rdv   = (kind == 0) || (kind == 2) || (kind == 4) || (kind == 5);
    wrv   = !rdv;
    load  = WAIT_CYCLES + (io ? IO_EXTRA : 0);
    width = ((load > r) ? load : r) + 1;
    sv    = {2'b00, rdv, wrv, sinta};
    set_z80(kind);
    hold_req = hold;
    set_ready(1'b1);
    for (int j = 0; j < 2 + width; j++) begin
      tick();
      if (j == 0)      expc = {4'b1000, sinta};
      else if (j == 1) expc = {4'b0100, sinta};
      else             expc = sv;
      tag = $sformatf("k%0d_r%0d_clk%0d", kind, r, j);
      check(tag, obs, ev(expc, 1'b0, 1'b0, 1'b0, 1'b1));
      set_ready(!(j >= 2 && (j - 2) < r));
    end
    tick();
    set_ready(1'b1);
    check($sformatf("k%0d_done", kind), obs, ev(5'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    extra = $urandom_range(0, 2);
    for (int e = 0; e < extra; e++) begin
      tick();
      check($sformatf("k%0d_done_hold%0d", kind, e), obs, ev(5'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    end
    set_z80(-1);
    tick();
    check($sformatf("k%0d_idle", kind), obs, ev(5'b0, 1'b0, 1'b0, 1'b1, 1'b0));
  endtask

  initial begin
    int n_hold;

    // Reset values, before any clock edge.
    reset = 1'b1;
    set_z80(-1);
    hold_req = 1'b0;
    set_ready(1'b1);
    #3;
    check("reset_state", obs, ev(5'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    #10 reset = 1'b0;
    tick();
    check("idle_after_reset", obs, ev(5'b0, 1'b0, 1'b0, 1'b1, 1'b0));

    // Reset in the middle of a write strobe clears outputs without a clock.
    set_z80(1);
    tick();
    tick();
    tick();
    check("wr_strobe_before_reset", obs, ev(5'b00010, 1'b0, 1'b0, 1'b0, 1'b1));
    #2 reset = 1'b1;
    #1;
    check("async_reset_mid_strobe", obs, ev(5'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    set_z80(-1);
    reset = 1'b0;
    tick();
    check("idle_after_mid_reset", obs, ev(5'b0, 1'b0, 1'b0, 1'b1, 1'b0));

    // Directed cycles.
    run_txn(0, 0, 1'b0);   // memory read, ready high
    run_txn(3, 5, 1'b0);   // I/O write, ready low 5 strobe clocks
    run_txn(4, 0, 1'b0);   // interrupt acknowledge
    run_txn(5, 0, 1'b0);   // rd and wr both low: read wins
    run_txn(1, 0, 1'b0);   // memory write, minimum strobe

    // Hold requested on the same edge as a read: read first, then HOLD.
    run_txn(0, 0, 1'b1);
    tick();
    check("hold_entry", obs, ev(5'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    tick();
    check("hold_granted", obs, ev(5'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    set_z80(0);
    tick();
    check("hold_z80_stalled", obs, ev(5'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    tick();
    check("hold_z80_stalled2", obs, ev(5'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    hold_req = 1'b0;
    tick();
    check("hold_release", obs, ev(5'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    run_txn(0, 0, 1'b0);   // pending read starts with SYNC next edge

    // Randomized cycles with occasional hold episodes.
    for (int t = 0; t < 24; t++) begin
      run_txn($urandom_range(0, 5), $urandom_range(0, 4), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        hold_req = 1'b1;
        tick();
        check($sformatf("rnd%0d_hold_entry", t), obs, ev(5'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        n_hold = $urandom_range(1, 3);
        for (int h = 0; h < n_hold; h++) begin
          tick();
          check($sformatf("rnd%0d_hold%0d", t, h), obs, ev(5'b0, 1'b1, 1'b1, 1'b1, 1'b1));
        end
        hold_req = 1'b0;
        tick();
        check($sformatf("rnd%0d_hold_release", t), obs, ev(5'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
